// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch (I) and EX-stage
//   load/store (D). At most one access is issued per cycle. D has priority, but I is forced
//   to win once it has lost STARVE_MAX consecutive contended cycles. Each read is tagged so
//   its response, one cycle later, returns to its owner. A taken branch (i_flush_i) discards
//   fetch responses still in flight.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req_i/i_addr_i         fetch read request and word address
//   i_flush_i                taken branch, drop in-flight fetch responses
//   i_stall_o                fetch request not accepted this cycle
//   i_rvalid_o/i_rdata_o     fetch response and its data
//   i_raddr_o                address of the returned fetch word
//   d_req_i/d_we_i           load/store request, 1 = store
//   d_addr_i/d_wdata_i       data address and store data
//   d_stall_o                data request not accepted this cycle
//   d_rvalid_o/d_rdata_o     load response and its data
//   mem_a_o/mem_w_o/mem_d_o  memory address, write enable, write data
//   mem_q_i                  memory read data, one cycle after the address

module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_flush_i,
  output logic              i_stall_o,
  output logic              i_rvalid_o,
  output logic [WORD_W-1:0] i_rdata_o,
  output logic [ADDR_W-1:0] i_raddr_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [WORD_W-1:0] d_wdata_i,
  output logic              d_stall_o,
  output logic              d_rvalid_o,
  output logic [WORD_W-1:0] d_rdata_o,

  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_w_o,
  output logic [WORD_W-1:0] mem_d_o,
  input  logic [WORD_W-1:0] mem_q_i
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  // Owner of the read response arriving on mem_q_i this cycle.
  typedef enum logic [1:0] {
    PendNone,
    PendI,
    PendIDrop,
    PendD
  } pend_e;

  pend_e             pend_q, pend_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  logic i_gnt, d_gnt;

  // ---------------------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------------------
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (i_req_i && (!d_req_i || (starve_q == StarveMaxC))) begin
        i_gnt = 1'b1;
      end else if (d_req_i) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Both stalls are forced high during reset, even without a request.
  assign i_stall_o = rst | (i_req_i & ~i_gnt);
  assign d_stall_o = rst | (d_req_i & ~d_gnt);

  // ---------------------------------------------------------------------------------------
  // Memory side: the granted request drives the macro combinationally; the address is
  // held from the last grant so the macro input does not toggle on idle cycles.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    mem_a_o = addr_q;
    mem_w_o = 1'b0;
    mem_d_o = '0;
    addr_d  = addr_q;
    if (i_gnt) begin
      mem_a_o = i_addr_i;
      addr_d  = i_addr_i;
    end else if (d_gnt) begin
      mem_a_o = d_addr_i;
      mem_w_o = d_we_i;
      mem_d_o = d_wdata_i;
      addr_d  = d_addr_i;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Starvation counter and response-tracking next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    starve_d = starve_q;
    if (i_gnt || !i_req_i) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != StarveMaxC)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_comb begin
    pend_d  = PendNone;
    raddr_d = raddr_q;
    if (i_gnt) begin
      // A fetch issued alongside a flush belongs to the old path: keep the slot but drop it.
      pend_d  = i_flush_i ? PendIDrop : PendI;
      raddr_d = i_addr_i;
    end else if (d_gnt && !d_we_i) begin
      pend_d = PendD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= PendNone;
      starve_q <= '0;
      addr_q   <= '0;
      raddr_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      raddr_q  <= raddr_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Responses: data comes straight from the macro, gated to zero when not valid.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    i_rvalid_o = !rst && (pend_q == PendI) && !i_flush_i;
    d_rvalid_o = !rst && (pend_q == PendD);
    i_rdata_o  = i_rvalid_o ? mem_q_i : '0;
    d_rdata_o  = d_rvalid_o ? mem_q_i : '0;
    i_raddr_o  = raddr_q;
  end

  // ---------------------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (rst) !(i_gnt && d_gnt));
  a_one_resp  : assert property (@(posedge clk) disable iff (rst) !(i_rvalid_o && d_rvalid_o));
  a_cnt_range : assert property (@(posedge clk) disable iff (rst) starve_q <= StarveMaxC);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              i_req, i_flush, i_stall, i_rvalid;
  logic [ADDR_W-1:0] i_addr, i_raddr;
  logic [WORD_W-1:0] i_rdata;
  logic              d_req, d_we, d_stall, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata, d_rdata;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_w;
  logic [WORD_W-1:0] mem_d, mem_q;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .WORD_W    (WORD_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_req_i   (i_req),
    .i_addr_i  (i_addr),
    .i_flush_i (i_flush),
    .i_stall_o (i_stall),
    .i_rvalid_o(i_rvalid),
    .i_rdata_o (i_rdata),
    .i_raddr_o (i_raddr),
    .d_req_i   (d_req),
    .d_we_i    (d_we),
    .d_addr_i  (d_addr),
    .d_wdata_i (d_wdata),
    .d_stall_o (d_stall),
    .d_rvalid_o(d_rvalid),
    .d_rdata_o (d_rdata),
    .mem_a_o   (mem_a),
    .mem_w_o   (mem_w),
    .mem_d_o   (mem_d),
    .mem_q_i   (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous memory macro, 256 words.
  logic [WORD_W-1:0] mem [256];
  logic [WORD_W-1:0] ref_mem [256];

  always @(posedge clk) begin
    mem_q <= mem[mem_a[7:0]];
    if (mem_w) mem[mem_a[7:0]] <= mem_d;
  end

  function automatic logic [WORD_W-1:0] init_word(input int a);
    return 32'hA500_0000 + 32'(a) * 32'h0001_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled 4 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  // Random-traffic model state
  int                cnt, pk;
  logic [ADDR_W-1:0] pa;
  logic [WORD_W-1:0] pdat;
  logic              exp_ig, exp_dg, prev_is, prev_ds;

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]     = init_word(a);
      ref_mem[a] = init_word(a);
    end
    idle_inputs();
    rst = 1;

    // ---- reset state: requests present but blocked, store must not reach the memory
    #1;
    i_req = 1; d_req = 1; d_we = 1; d_addr = 16'h0044; d_wdata = 32'h1234_5678;
    #4;
    check("rst_i_stall", 32'(i_stall), 1);
    check("rst_d_stall", 32'(d_stall), 1);
    check("rst_mem_w", 32'(mem_w), 0);
    check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 0);
    next_cycle();
    idle_inputs();
    #4;
    check("rst_idle_stalls", 32'({i_stall, d_stall}), 32'b11);
    check("rst_mem_a", 32'(mem_a), 0);
    check("rst_raddr", 32'(i_raddr), 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    next_cycle();
    rst = 0;
    #4;
    check("post_rst_stalls", 32'({i_stall, d_stall}), 0);

    // ---- 1: fetch-only stream, addresses 0..3 back to back
    for (int k = 0; k <= 5; k++) begin
      next_cycle();
      i_req  = (k < 4);
      i_addr = 16'(k);
      #4;
      check("t1_i_stall", 32'(i_stall), 0);
      check("t1_i_rvalid", 32'(i_rvalid), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) begin
        check("t1_i_rdata", i_rdata, init_word(k - 1));
        check("t1_i_raddr", 32'(i_raddr), 32'(k - 1));
      end else begin
        check("t1_i_rdata_zero", i_rdata, 0);
      end
    end
    check("t1_mem_a_hold", 32'(mem_a), 3);

    // ---- 2: both requesting continuously; D wins 4, I wins the 5th
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      i_req = 1; i_addr = 16'h0030;
      d_req = 1; d_we = 0; d_addr = 16'h0020;
      #4;
      check("t2_i_stall", 32'(i_stall), 32'(k % 5 != 4));
      check("t2_d_stall", 32'(d_stall), 32'(k % 5 == 4));
      check("t2_one_grant", 32'(!i_stall && !d_stall), 0);
      if (k > 0) begin
        check("t2_d_rvalid", 32'(d_rvalid), 32'(k % 5 != 0));
        check("t2_i_rvalid", 32'(i_rvalid), 32'(k % 5 == 0));
      end
    end
    next_cycle();
    idle_inputs();
    #4;
    check("t2_last_i_rvalid", 32'(i_rvalid), 1);
    check("t2_last_i_rdata", i_rdata, init_word(16'h30));
    check("t2_last_i_raddr", 32'(i_raddr), 32'h30);

    // ---- 3: store 0xDEADBEEF @0x10, then load @0x10
    next_cycle();
    d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 32'hDEAD_BEEF;
    #4;
    check("t3_st_stall", 32'(d_stall), 0);
    check("t3_st_mem_w", 32'(mem_w), 1);
    check("t3_st_mem_a", 32'(mem_a), 32'h10);
    check("t3_st_mem_d", mem_d, 32'hDEAD_BEEF);
    next_cycle();
    d_we = 0; d_wdata = '0;
    #4;
    check("t3_ld_mem_w", 32'(mem_w), 0);
    check("t3_st_no_resp", 32'({i_rvalid, d_rvalid}), 0);
    next_cycle();
    idle_inputs();
    #4;
    check("t3_ld_rvalid", 32'(d_rvalid), 1);
    check("t3_ld_rdata", d_rdata, 32'hDEAD_BEEF);
    check("t3_no_i_rvalid", 32'(i_rvalid), 0);
    ref_mem[8'h10] = 32'hDEAD_BEEF;

    // ---- 4a: fetch accepted, flush in the response cycle
    next_cycle();
    i_req = 1; i_addr = 16'h0005;
    #4;
    check("t4a_accept", 32'(i_stall), 0);
    next_cycle();
    idle_inputs();
    i_flush = 1;
    #4;
    check("t4a_rvalid", 32'(i_rvalid), 0);
    check("t4a_rdata", i_rdata, 0);
    // ---- 4b: flush in the accept cycle; request is still arbitrated
    next_cycle();
    i_flush = 1; i_req = 1; i_addr = 16'h0006;
    #4;
    check("t4b_accept", 32'(i_stall), 0);
    next_cycle();
    idle_inputs();
    #4;
    check("t4b_rvalid", 32'(i_rvalid), 0);
    // ---- 4c: next fetch after flush is normal
    next_cycle();
    i_req = 1; i_addr = 16'h0007;
    #4;
    next_cycle();
    idle_inputs();
    #4;
    check("t4c_rvalid", 32'(i_rvalid), 1);
    check("t4c_rdata", i_rdata, init_word(7));

    // ---- 5: reset while a load is in flight
    next_cycle();
    d_req = 1; d_we = 0; d_addr = 16'h0021;
    #4;
    check("t5_accept", 32'(d_stall), 0);
    next_cycle();
    rst = 1; i_req = 1; i_addr = 16'h0009; d_we = 1; d_wdata = 32'hFFFF_FFFF;
    #4;
    check("t5_rst_d_rvalid", 32'(d_rvalid), 0);
    check("t5_rst_d_rdata", d_rdata, 0);
    check("t5_rst_stalls", 32'({i_stall, d_stall}), 32'b11);
    check("t5_rst_mem_w", 32'(mem_w), 0);
    next_cycle();
    rst = 0;
    idle_inputs();
    i_req = 1; i_addr = 16'h0000;
    #4;
    check("t5_post_stall", 32'(i_stall), 0);
    check("t5_post_mem_a", 32'(mem_a), 0);
    check("t5_post_rvalid", 32'({i_rvalid, d_rvalid}), 0);
    next_cycle();
    i_addr = 16'h0001;
    #4;
    check("t5_post_rdata0", i_rdata, init_word(0));
    check("t5_post_raddr0", 32'(i_raddr), 0);
    next_cycle();
    idle_inputs();
    #4;
    check("t5_post_rdata1", i_rdata, init_word(1));
    check("t5_post_raddr1", 32'(i_raddr), 1);

    // ---- 6: random mixed traffic against a reference model
    next_cycle();
    #4;
    cnt = 0; pk = 0; pa = '0; pdat = '0; prev_is = 0; prev_ds = 0;
    for (int k = 0; k < 300; k++) begin
      next_cycle();
      if (!(i_req && prev_is)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = 16'($urandom_range(0, 63));
      end
      if (!(d_req && prev_ds)) begin
        d_req   = ($urandom_range(0, 1) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = 16'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      i_flush = ($urandom_range(0, 7) == 0);
      #4;
      exp_ig = i_req && (!d_req || cnt == STARVE_MAX);
      exp_dg = d_req && !exp_ig;
      check("t6_i_stall", 32'(i_stall), 32'(i_req && !exp_ig));
      check("t6_d_stall", 32'(d_stall), 32'(d_req && !exp_dg));
      check("t6_i_rvalid", 32'(i_rvalid), 32'(pk == 1 && !i_flush));
      check("t6_d_rvalid", 32'(d_rvalid), 32'(pk == 2));
      if (pk == 1 && !i_flush) begin
        check("t6_i_rdata", i_rdata, pdat);
        check("t6_i_raddr", 32'(i_raddr), 32'(pa));
      end
      if (pk == 2) check("t6_d_rdata", d_rdata, pdat);
      if (exp_dg) check("t6_mem_w", 32'(mem_w), 32'(d_we));
      // advance model
      if (exp_ig) begin
        pk = i_flush ? 3 : 1; pa = i_addr; pdat = ref_mem[i_addr[7:0]];
      end else if (exp_dg && !d_we) begin
        pk = 2; pdat = ref_mem[d_addr[7:0]];
      end else begin
        pk = 0;
      end
      if (exp_dg && d_we) ref_mem[d_addr[7:0]] = d_wdata;
      if (exp_ig || !i_req) cnt = 0;
      else if (exp_dg) cnt++;
      prev_is = i_req && !exp_ig;
      prev_ds = d_req && !exp_dg;
    end
    next_cycle();
    idle_inputs();
    #4;
    check("t6_tail_i_rvalid", 32'(i_rvalid), 32'(pk == 1));
    check("t6_tail_d_rvalid", 32'(d_rvalid), 32'(pk == 2));
    if (pk == 1) check("t6_tail_i_rdata", i_rdata, pdat);
    if (pk == 2) check("t6_tail_d_rdata", d_rdata, pdat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
